// File: rtl/msrh_l1d_wb_queue.sv
// L1D write-back queue: buffers evicted dirty lines, issues them in order to L2,
// and frees entries on (possibly out-of-order) L2 write acknowledges.
// Optional feature macro: MSRH_WB_SEARCH_FWD_EN. When it is defined, o_search_data
// forwards the youngest matching line. Otherwise o_search_data is tied to zero.
module msrh_l1d_wb_queue #(
  parameter int unsigned WB_ENTRY_NUM = 4,
  parameter int unsigned PADDR_W      = 56,
  parameter int unsigned LINE_W       = 512,
  parameter int unsigned TAG_W        = 8
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  // Eviction intake
  input  logic               i_evict_valid,
  output logic               o_evict_ready,
  input  logic [PADDR_W-1:0] i_evict_paddr,
  input  logic [LINE_W-1:0]  i_evict_data,
  // L2 write request / acknowledge
  output logic               o_l2_req_valid,
  input  logic               i_l2_req_ready,
  output logic [PADDR_W-1:0] o_l2_req_paddr,
  output logic [LINE_W-1:0]  o_l2_req_data,
  output logic [TAG_W-1:0]   o_l2_req_tag,
  input  logic               i_l2_resp_valid,
  input  logic [TAG_W-1:0]   i_l2_resp_tag,
  // Miss-unit search
  input  logic               i_search_valid,
  input  logic [PADDR_W-1:0] i_search_paddr,
  output logic               o_search_hit,
  output logic [LINE_W-1:0]  o_search_data,
  output logic               o_empty
);

  localparam int unsigned IdxW = (WB_ENTRY_NUM > 1) ? $clog2(WB_ENTRY_NUM) : 1;

  typedef enum logic [1:0] {
    StInvalid = 2'd0,
    StReady   = 2'd1,
    StIssued  = 2'd2
  } wb_state_e;

  wb_state_e           state_q [WB_ENTRY_NUM];
  wb_state_e           state_d [WB_ENTRY_NUM];
  logic [PADDR_W-1:0]  paddr_q [WB_ENTRY_NUM];
  logic [LINE_W-1:0]   data_q  [WB_ENTRY_NUM];
  logic [IdxW-1:0]     tail_q, tail_d;
  logic [IdxW-1:0]     issue_q, issue_d;
  logic                empty_q, empty_d;

  logic                alloc_fire;
  logic                issue_fire;
  logic                ack_fire;
  logic [IdxW-1:0]     ack_idx;
  logic                ack_in_range;
  logic [WB_ENTRY_NUM-1:0] line_match;

  // Line offset bits never take part in matching.
  logic unused_search_offset;
  assign unused_search_offset = ^i_search_paddr[5:0];

  // Handshake decode from registered state only; a same-cycle ack never frees a slot early.
  always_comb begin
    o_evict_ready  = (state_q[tail_q] == StInvalid);
    o_l2_req_valid = (state_q[issue_q] == StReady);
    alloc_fire     = i_evict_valid & o_evict_ready;
    issue_fire     = o_l2_req_valid & i_l2_req_ready;
    ack_idx        = i_l2_resp_tag[IdxW-1:0];
    // Tags beyond the entry range must not alias onto a real entry.
    ack_in_range   = ((i_l2_resp_tag >> IdxW) == '0);
    ack_fire       = i_l2_resp_valid & ack_in_range & (state_q[ack_idx] == StIssued);
  end

  // Request fields come straight from the entry at the issue pointer, stable while stalled.
  always_comb begin
    o_l2_req_paddr = paddr_q[issue_q];
    o_l2_req_data  = data_q[issue_q];
    o_l2_req_tag   = TAG_W'(issue_q);
    o_empty        = empty_q;
  end

  // Next-state: alloc, issue and ack always target distinct entries (distinct source states).
  always_comb begin
    for (int i = 0; i < WB_ENTRY_NUM; i++) begin
      state_d[i] = state_q[i];
    end
    tail_d  = tail_q;
    issue_d = issue_q;
    if (alloc_fire) begin
      state_d[tail_q] = StReady;
      tail_d          = tail_q + IdxW'(1);
    end
    if (issue_fire) begin
      state_d[issue_q] = StIssued;
      issue_d          = issue_q + IdxW'(1);
    end
    if (ack_fire) begin
      state_d[ack_idx] = StInvalid;
    end
    empty_d = 1'b1;
    for (int i = 0; i < WB_ENTRY_NUM; i++) begin
      if (state_d[i] != StInvalid) empty_d = 1'b0;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < WB_ENTRY_NUM; i++) begin
        state_q[i] <= StInvalid;
      end
      tail_q  <= '0;
      issue_q <= '0;
      empty_q <= 1'b1;
    end else begin
      for (int i = 0; i < WB_ENTRY_NUM; i++) begin
        state_q[i] <= state_d[i];
      end
      tail_q  <= tail_d;
      issue_q <= issue_d;
      empty_q <= empty_d;
    end
  end

  // Payload storage; contents only matter while the entry is non-INVALID, so no reset.
  always_ff @(posedge i_clk) begin
    if (alloc_fire) begin
      paddr_q[tail_q] <= i_evict_paddr;
      data_q[tail_q]  <= i_evict_data;
    end
  end

  // Per-entry line compare against READY/ISSUED entries; a just-allocated entry is still INVALID.
  always_comb begin
    for (int i = 0; i < WB_ENTRY_NUM; i++) begin
      line_match[i] = (state_q[i] != StInvalid) &&
                      (paddr_q[i][PADDR_W-1:6] == i_search_paddr[PADDR_W-1:6]);
    end
    o_search_hit = i_search_valid & (|line_match);
  end

`ifdef MSRH_WB_SEARCH_FWD_EN
  // Walk oldest (tail) to youngest (tail-1) so the last match seen is the youngest.
  always_comb begin
    logic [IdxW-1:0] idx;
    o_search_data = '0;
    for (int k = 0; k < WB_ENTRY_NUM; k++) begin
      idx = tail_q + IdxW'(k);
      if (i_search_valid && line_match[idx]) o_search_data = data_q[idx];
    end
  end
`else
  assign o_search_data = '0;
`endif

endmodule

// File: tb/tb_msrh_l1d_wb_queue.sv
// Directed bench for msrh_l1d_wb_queue (default parameters). Inputs change on the
// falling edge, outputs are sampled 1ns later, state updates on the rising edge.
module tb_msrh_l1d_wb_queue;

  localparam int unsigned PW = 56;
  localparam int unsigned LW = 512;
  localparam int unsigned TW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          evict_valid = 1'b0;
  logic          evict_ready;
  logic [PW-1:0] evict_paddr = '0;
  logic [LW-1:0] evict_data = '0;
  logic          req_valid;
  logic          req_ready = 1'b0;
  logic [PW-1:0] req_paddr;
  logic [LW-1:0] req_data;
  logic [TW-1:0] req_tag;
  logic          resp_valid = 1'b0;
  logic [TW-1:0] resp_tag = '0;
  logic          search_valid = 1'b0;
  logic [PW-1:0] search_paddr = '0;
  logic          search_hit;
  logic [LW-1:0] search_data;
  logic          empty;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  msrh_l1d_wb_queue dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_evict_valid  (evict_valid),
    .o_evict_ready  (evict_ready),
    .i_evict_paddr  (evict_paddr),
    .i_evict_data   (evict_data),
    .o_l2_req_valid (req_valid),
    .i_l2_req_ready (req_ready),
    .o_l2_req_paddr (req_paddr),
    .o_l2_req_data  (req_data),
    .o_l2_req_tag   (req_tag),
    .i_l2_resp_valid(resp_valid),
    .i_l2_resp_tag  (resp_tag),
    .i_search_valid (search_valid),
    .i_search_paddr (search_paddr),
    .o_search_hit   (search_hit),
    .o_search_data  (search_data),
    .o_empty        (empty)
  );

  function automatic logic [LW-1:0] mkd(input logic [PW-1:0] a);
    return {8{8'hA5, a}};
  endfunction

  // Expected forwarded data depends on the build option.
  function automatic logic [LW-1:0] fwd(input logic [LW-1:0] d);
`ifdef MSRH_WB_SEARCH_FWD_EN
    return d;
`else
    return '0 & d;
`endif
  endfunction

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic evict(input logic [PW-1:0] a);
    evict_valid = 1'b1;
    evict_paddr = a;
    evict_data  = mkd(a);
  endtask

  task automatic search(input logic [PW-1:0] a);
    search_valid = 1'b1;
    search_paddr = a;
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    tick();
    search(56'h1000);
    #1;
    chk("rst_evict_ready", LW'(evict_ready), 1);
    chk("rst_req_valid", LW'(req_valid), 0);
    chk("rst_search_hit", LW'(search_hit), 0);
    chk("rst_empty", LW'(empty), 1);
    chk("rst_search_data", search_data, 0);
    tick();

    // Single eviction, 1-cycle latency, ack empties
    rst_n = 1'b1;
    evict(56'h1000);
    req_ready = 1'b1;
    #1;
    chk("t1_ready", LW'(evict_ready), 1);
    chk("t1_no_bypass", LW'(req_valid), 0);
    chk("t1_alloc_no_hit", LW'(search_hit), 0);
    tick();
    evict_valid = 1'b0;
    search_valid = 1'b0;
    #1;
    chk("t1_req_valid", LW'(req_valid), 1);
    chk("t1_req_tag", LW'(req_tag), 0);
    chk("t1_req_paddr", LW'(req_paddr), 56'h1000);
    chk("t1_req_data", req_data, mkd(56'h1000));
    chk("t1_not_empty", LW'(empty), 0);
    tick();
    #1;
    chk("t1_issued", LW'(req_valid), 0);
    resp_valid = 1'b1;
    resp_tag = 8'd0;
    search(56'h1000);
    #1;
    chk("t1_ack_cycle_hit", LW'(search_hit), 1);
    tick();
    resp_valid = 1'b0;
    search_valid = 1'b0;
    #1;
    chk("t1_empty", LW'(empty), 1);

    // Fill with L2 stalled; tail starts at entry 1
    req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      evict(56'h1000 + PW'(k) * 56'h100);
      #1;
      chk("t2_fill_ready", LW'(evict_ready), 1);
      tick();
    end
    evict(56'h1400);
    #1;
    chk("t2_full_ready", LW'(evict_ready), 0);
    chk("t2_req_tag", LW'(req_tag), 1);
    chk("t2_req_paddr", LW'(req_paddr), 56'h1000);
    tick();
    #1;
    chk("t2_stable_tag", LW'(req_tag), 1);
    chk("t2_stable_paddr", LW'(req_paddr), 56'h1000);
    chk("t2_held", LW'(evict_ready), 0);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    resp_valid = 1'b1;
    resp_tag = 8'd1;
    #1;
    chk("t2_ack_not_same_cycle", LW'(evict_ready), 0);
    chk("t2_next_tag", LW'(req_tag), 2);
    chk("t2_next_paddr", LW'(req_paddr), 56'h1100);
    tick();
    resp_valid = 1'b0;
    #1;
    chk("t2_slot_free", LW'(evict_ready), 1);
    tick();
    evict_valid = 1'b0;
    #1;
    chk("t2_one_slot_only", LW'(evict_ready), 0);

    // Asynchronous reset while full
    rst_n = 1'b0;
    #1;
    chk("t2_rst_empty", LW'(empty), 1);
    chk("t2_rst_req_valid", LW'(req_valid), 0);
    chk("t2_rst_ready", LW'(evict_ready), 1);
    tick();
    rst_n = 1'b1;

    // Issue tags 0,1,2 with concurrent allocation, out-of-order acks 2,0,1
    req_ready = 1'b1;
    evict(56'h3000);
    #1;
    chk("t3_a_req_valid", LW'(req_valid), 0);
    tick();
    evict(56'h3040);
    #1;
    chk("t3_tag0", LW'(req_tag), 0);
    chk("t3_tag0_valid", LW'(req_valid), 1);
    tick();
    evict(56'h3080);
    #1;
    chk("t3_tag1", LW'(req_tag), 1);
    tick();
    evict(56'h30C0);
    #1;
    chk("t3_tag2", LW'(req_tag), 2);
    tick();
    evict(56'h3100);
    req_ready = 1'b0;
    resp_valid = 1'b1;
    resp_tag = 8'd2;
    search(56'h3080);
    #1;
    chk("t3_e_ready", LW'(evict_ready), 0);
    chk("t3_e_hit_acked", LW'(search_hit), 1);
    chk("t3_e_tag3", LW'(req_tag), 3);
    tick();
    resp_tag = 8'd0;
    #1;
    chk("t3_f_freed2", LW'(search_hit), 0);
    chk("t3_f_ready", LW'(evict_ready), 0);
    tick();
    #1;
    chk("t3_g_ready", LW'(evict_ready), 1);
    resp_tag = 8'd1;
    req_ready = 1'b1;
    tick();
    evict_valid = 1'b0;
    resp_valid = 1'b0;
    req_ready = 1'b0;
    search(56'h30C0);
    #1;
    chk("t3_h_req_valid", LW'(req_valid), 1);
    chk("t3_h_tag0", LW'(req_tag), 0);
    chk("t3_h_paddr", LW'(req_paddr), 56'h3100);
    chk("t3_h_ready", LW'(evict_ready), 1);
    chk("t3_h_hit_e3", LW'(search_hit), 1);

    // Search hits, offset ignored, youngest duplicate wins
    evict(56'h2040);
    tick();
    evict(56'h2040);
    evict_data = mkd(56'h2041);
    search(56'h2078);
    #1;
    chk("t4_hit", LW'(search_hit), 1);
    chk("t4_data", search_data, fwd(mkd(56'h2040)));
    search(56'h2080);
    #1;
    chk("t4_miss", LW'(search_hit), 0);
    chk("t4_miss_data", search_data, 0);
    tick();
    evict_valid = 1'b0;
    search(56'h2040);
    #1;
    chk("t4_dup_hit", LW'(search_hit), 1);
    chk("t4_youngest", search_data, fwd(mkd(56'h2041)));
    search_valid = 1'b0;
    #1;
    chk("t4_no_valid", LW'(search_hit), 0);
    resp_valid = 1'b1;
    resp_tag = 8'd3;
    tick();

    // Acks to INVALID entries and out-of-range tags are ignored
    req_ready = 1'b1;
    resp_tag = 8'd3;
    #1;
    chk("t5_ready", LW'(evict_ready), 1);
    tick();
    req_ready = 1'b0;
    resp_tag = 8'd4;
    search(56'h3100);
    #1;
    chk("t5_hit_issued", LW'(search_hit), 1);
    chk("t5_req_tag1", LW'(req_tag), 1);
    tick();
    resp_tag = 8'd0;
    #1;
    chk("t5_tag4_ignored", LW'(search_hit), 1);
    tick();
    resp_valid = 1'b0;
    #1;
    chk("t5_acked", LW'(search_hit), 0);

    // Reset with two ISSUED entries, then a late ack
    req_ready = 1'b1;
    tick();
    tick();
    req_ready = 1'b0;
    #1;
    chk("t6_not_empty", LW'(empty), 0);
    rst_n = 1'b0;
    search(56'h2040);
    #1;
    chk("t6_rst_empty", LW'(empty), 1);
    chk("t6_rst_req_valid", LW'(req_valid), 0);
    chk("t6_rst_hit", LW'(search_hit), 0);
    chk("t6_rst_data", search_data, 0);
    tick();
    rst_n = 1'b1;
    search_valid = 1'b0;
    resp_valid = 1'b1;
    resp_tag = 8'd1;
    tick();
    resp_valid = 1'b0;
    #1;
    chk("t6_late_ack_empty", LW'(empty), 1);
    chk("t6_late_ack_req", LW'(req_valid), 0);
    evict(56'h5000);
    tick();
    evict_valid = 1'b0;
    #1;
    chk("t6_ptr_tag0", LW'(req_tag), 0);
    chk("t6_ptr_paddr", LW'(req_paddr), 56'h5000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/msrh_l1d_wb_queue.md
MSRH_L1D_WB_QUEUE -- requirements
Module: msrh_l1d_wb_queue

Interface
REQ-001 SHALL have parameter WB_ENTRY_NUM, default 4 (power of 2, min 2), number of write-back entries.
REQ-002 SHALL have parameter PADDR_W, default 56, physical address width.
REQ-003 SHALL have parameter LINE_W, default 512, cache line data width.
REQ-004 SHALL have parameter TAG_W, default 8, L2 request tag width (>= log2(WB_ENTRY_NUM)).
REQ-005 i_clk  in  1  clock; all state on rising edge.
REQ-006 i_reset_n  in  1  reset, asynchronous, active-low.
REQ-007 i_evict_valid  in  1  dcache evicted dirty line offered.
REQ-008 o_evict_ready  out  1  queue can accept the offered eviction this cycle.
REQ-009 i_evict_paddr  in  PADDR_W  line-aligned eviction address.
REQ-010 i_evict_data  in  LINE_W  eviction line data.
REQ-011 o_l2_req_valid  out  1  L2 write request valid.
REQ-012 i_l2_req_ready  in  1  L2 accepts request this cycle.
REQ-013 o_l2_req_paddr  out  PADDR_W  request address.
REQ-014 o_l2_req_data  out  LINE_W  request data.
REQ-015 o_l2_req_tag  out  TAG_W  request tag, zero-extended entry index.
REQ-016 i_l2_resp_valid  in  1  L2 write acknowledge.
REQ-017 i_l2_resp_tag  in  TAG_W  acknowledged tag.
REQ-018 i_search_valid  in  1  miss-unit line search request.
REQ-019 i_search_paddr  in  PADDR_W  searched address (line offset ignored).
REQ-020 o_search_hit  out  1  searched line pending write-back.
REQ-021 o_search_data  out  LINE_W  data of matching entry (see Configuration).
REQ-022 o_empty  out  1  all entries INVALID.

Function
REQ-023 Each entry SHALL hold state INVALID, READY or ISSUED, plus paddr and data.
REQ-024 Allocation SHALL use a circular tail pointer; o_evict_ready = (state[tail]==INVALID), combinational.
REQ-025 i_evict_valid & o_evict_ready SHALL write the entry at tail to READY and advance tail, wrapping WB_ENTRY_NUM-1 -> 0.
REQ-026 Issue SHALL use a circular issue pointer; o_l2_req_valid = (state[issue]==READY); paddr/data/tag taken from that entry.
REQ-027 Earliest o_l2_req_valid SHALL be the cycle after acceptance (1-cycle latency); no bypass.
REQ-028 Request fields SHALL stay stable while o_l2_req_valid & !i_l2_req_ready.
REQ-029 o_l2_req_valid & i_l2_req_ready SHALL move the entry to ISSUED and advance the issue pointer (wrap as REQ-025).
REQ-030 i_l2_resp_valid with tag of an ISSUED entry SHALL set that entry INVALID; acks may arrive out of order.
REQ-031 Ack with tag of a non-ISSUED entry or tag >= WB_ENTRY_NUM SHALL be ignored.
REQ-032 Entry freed by ack in cycle N SHALL NOT be allocatable until N+1 (o_evict_ready uses registered state).
REQ-033 Allocation, issue and ack in the same cycle on different entries SHALL all take effect.
REQ-034 Full: all entries non-INVALID implies o_evict_ready=0; evictions stall, nothing dropped.
REQ-035 o_search_hit SHALL be combinational: i_search_valid & any READY/ISSUED entry with paddr[PADDR_W-1:6]==i_search_paddr[PADDR_W-1:6].
REQ-036 An entry allocated in the current cycle SHALL NOT hit; an entry acked in the current cycle SHALL still hit.
REQ-037 Two valid entries with the same line SHALL be legal; the search selects the youngest (closest behind tail).
REQ-038 o_empty SHALL be registered state, 1 when no entry is READY or ISSUED.

Reset
REQ-039 Asserting i_reset_n low at any time SHALL set all entries INVALID, both pointers to 0, and discard in-flight requests.
REQ-040 During reset: o_evict_ready=1, o_l2_req_valid=0, o_search_hit=0, o_empty=1, o_search_data=0.

Configuration
REQ-041 With MSRH_WB_SEARCH_FWD_EN defined, o_search_data SHALL carry the youngest matching entry's data when o_search_hit=1, else 0.
REQ-042 Without MSRH_WB_SEARCH_FWD_EN, o_search_data SHALL be constant 0, no data mux is built, and o_search_hit behaves unchanged.

Verification
REQ-043 Evict paddr 0x1000 at cycle 1, ready=1 -> o_l2_req_valid at cycle 2, tag 0; ack tag 0 -> o_empty=1 next cycle.
REQ-044 Four evictions 0x1000..0x1300, L2 ready=0 -> o_evict_ready=0 after fourth; fifth held; ack after ready releases exactly one slot.
REQ-045 Issue tags 0,1,2; ack order 2,0,1 -> each entry freed on its own ack; tail reuses entry 0 only after ack 0.
REQ-046 Entry 1 READY for 0x2040, search 0x2078 -> hit=1, data = entry data (FWD_EN); search 0x2080 -> hit=0.
REQ-047 Ack tag 3 while entry 3 INVALID -> no state change; ack and search of same line same cycle -> hit=1.
REQ-048 Reset asserted with 2 ISSUED entries -> immediately empty, o_l2_req_valid=0; late ack for tag 1 afterwards ignored.
